// File: rtl/div_arbiter_if.sv
// Bus bundle between the requesters, the response consumer, the shared divider
// and div_arbiter.
//   req_*  : per-requester valid/ready plus packed operands (requester i at [i*N +: N])
//   resp_* : single tagged response channel (valid/ready)
//   div_*  : start pulse, operands, completion pulse and results of the divider
// slave modport is the arbiter's view; master modport is the environment's view.
interface div_arbiter_if #(
  parameter int unsigned N    = 16,
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_dividend;
  logic [NREQ*N-1:0] req_divisor;

  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [N-1:0]      resp_quotient;
  logic [N-1:0]      resp_remainder;
  logic              resp_dbz;

  logic              div_start;
  logic [N-1:0]      div_dividend;
  logic [N-1:0]      div_divisor;
  logic              div_done;
  logic [N-1:0]      div_quotient;
  logic [N-1:0]      div_remainder;

  modport slave (
    input  req_valid, req_dividend, req_divisor, resp_ready,
           div_done, div_quotient, div_remainder,
    output req_ready, resp_valid, resp_id, resp_quotient, resp_remainder,
           resp_dbz, div_start, div_dividend, div_divisor
  );

  modport master (
    output req_valid, req_dividend, req_divisor, resp_ready,
           div_done, div_quotient, div_remainder,
    input  req_ready, resp_valid, resp_id, resp_quotient, resp_remainder,
           resp_dbz, div_start, div_dividend, div_divisor
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative unsigned divider among
// NREQ requesters. Divide-by-zero is answered locally without the divider.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high (divider must share it)
//   bus   : div_arbiter_if.slave (request, response and divider channels)
//   busy  : high in every state except IDLE
module div_arbiter #(
  parameter int unsigned N    = 16,
  parameter int unsigned NREQ = 4
) (
  input  logic            clk,
  input  logic            reset,
  div_arbiter_if.slave    bus,
  output logic            busy
);
  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    resp_id_q, resp_id_d;
  logic [N-1:0]      dividend_q, dividend_d;
  logic [N-1:0]      divisor_q, divisor_d;
  logic [N-1:0]      quot_q, quot_d;
  logic [N-1:0]      rem_q, rem_d;
  logic              dbz_q, dbz_d;
  logic              resp_valid_q, resp_valid_d;
  logic              div_start_q, div_start_d;
  logic              busy_q, busy_d;

  logic [IDW-1:0]    winner;
  logic [IDW-1:0]    cand;
  logic              found;
  logic [N-1:0]      sel_dividend;
  logic [N-1:0]      sel_divisor;
  logic [NREQ-1:0]   req_ready_c;

  // Winner: first valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(rr_ptr_q) + k) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign sel_dividend = bus.req_dividend[32'(winner)*N +: N];
  assign sel_divisor  = bus.req_divisor[32'(winner)*N +: N];

  // Next-state, datapath capture and registered-output targets.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    resp_id_d   = resp_id_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dbz_d       = dbz_q;
    req_ready_c = '0;

    case (state_q)
      IDLE: begin
        if (found && !reset) begin
          req_ready_c[winner] = 1'b1;
          resp_id_d  = winner;
          dividend_d = sel_dividend;
          divisor_d  = sel_divisor;
          rr_ptr_d   = (32'(winner) == NREQ - 1) ? '0 : winner + IDW'(1);
          if (sel_divisor == '0) begin
            // Answered locally: all-ones quotient, dividend as remainder.
            quot_d  = '1;
            rem_d   = sel_dividend;
            dbz_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.div_done) begin
          quot_d  = bus.div_quotient;
          rem_d   = bus.div_remainder;
          dbz_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    resp_valid_d = (state_d == RESP);
    div_start_d  = (state_d == ISSUE);
    busy_d       = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      resp_id_q    <= '0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      quot_q       <= '0;
      rem_q        <= '0;
      dbz_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      div_start_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      resp_id_q    <= resp_id_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      quot_q       <= quot_d;
      rem_q        <= rem_d;
      dbz_q        <= dbz_d;
      resp_valid_q <= resp_valid_d;
      div_start_q  <= div_start_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req_ready      = req_ready_c;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_id        = resp_id_q;
  assign bus.resp_quotient  = quot_q;
  assign bus.resp_remainder = rem_q;
  assign bus.resp_dbz       = dbz_q;
  assign bus.div_start      = div_start_q;
  assign bus.div_dividend   = dividend_q;
  assign bus.div_divisor    = divisor_q;
  assign busy               = busy_q;
endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: transaction-level model checked every
// cycle, behavioural divider with programmable latency, directed scenarios with
// literal expectations.
module tb_div_arbiter;
  localparam int unsigned N    = 16;
  localparam int unsigned NREQ = 4;

  logic clk;
  logic reset;
  logic busy;
  int   cyc;
  int   errors;
  int   checks;

  div_arbiter_if #(.N(N), .NREQ(NREQ)) bus();

  div_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void fail_timeout(string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
  endfunction

  // Behavioural divider: done pulse div_lat cycles after the start cycle.
  int          div_lat;
  int          dcnt;
  logic        mdone;
  logic        spur;
  logic [N-1:0] ma, mb, mq, mr;

  initial begin
    dcnt = 0; mdone = 1'b0; ma = '0; mb = '1; spur = 1'b0; div_lat = 3;
  end

  always @(posedge clk) begin
    #1;
    if (reset) begin
      dcnt  = 0;
      mdone = 1'b0;
    end else if (bus.div_start) begin
      dcnt  = div_lat;
      mdone = 1'b0;
      ma    = bus.div_dividend;
      mb    = bus.div_divisor;
    end else if (dcnt > 0) begin
      dcnt  = dcnt - 1;
      mdone = (dcnt == 0);
    end else begin
      mdone = 1'b0;
    end
  end

  assign mq = (mb == '0) ? '1 : ma / mb;
  assign mr = (mb == '0) ? ma : ma % mb;
  assign bus.div_done      = mdone | spur;
  assign bus.div_quotient  = spur ? 16'hDEAD : mq;
  assign bus.div_remainder = spur ? 16'hBEEF : mr;

  // Transaction model: who wins, when start/response must appear, what they carry.
  int          m_rr    = 0;
  bit          m_busy  = 0;
  bit          m_wait  = 0;
  bit          m_resp  = 0;
  int          m_start = -1;
  int          m_id    = 0;
  logic [N-1:0] m_q = '0, m_r = '0, m_a = '0, m_b = '0;
  bit          m_dbz   = 0;

  always @(negedge clk) begin
    int w;
    logic [NREQ-1:0] exp_rdy;
    logic [N-1:0] a, b;
    w = -1;
    if (!reset && !m_busy)
      for (int k = 0; k < int'(NREQ); k++) begin
        int idx;
        idx = (m_rr + k) % int'(NREQ);
        if (w < 0 && bus.req_valid[idx]) w = idx;
      end
    exp_rdy = (w >= 0) ? (NREQ'(1) << w) : '0;

    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("div_start", 32'(bus.div_start), 32'(!reset && cyc == m_start));
    chk("resp_valid", 32'(bus.resp_valid), 32'(!reset && m_resp));
    chk("busy", 32'(busy), 32'(!reset && m_busy));
    chk("div_dividend", 32'(bus.div_dividend), reset ? 32'd0 : 32'(m_a));
    chk("div_divisor", 32'(bus.div_divisor), reset ? 32'd0 : 32'(m_b));
    if (reset) begin
      chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
      chk("rst_resp_q", 32'(bus.resp_quotient), 32'd0);
      chk("rst_resp_r", 32'(bus.resp_remainder), 32'd0);
      chk("rst_resp_dbz", 32'(bus.resp_dbz), 32'd0);
    end else if (m_resp) begin
      chk("resp_id", 32'(bus.resp_id), 32'(m_id));
      chk("resp_q", 32'(bus.resp_quotient), 32'(m_q));
      chk("resp_r", 32'(bus.resp_remainder), 32'(m_r));
      chk("resp_dbz", 32'(bus.resp_dbz), 32'(m_dbz));
    end

    if (reset) begin
      m_rr = 0; m_busy = 0; m_wait = 0; m_resp = 0; m_start = -1;
      m_id = 0; m_q = '0; m_r = '0; m_a = '0; m_b = '0; m_dbz = 0;
    end else if (w >= 0) begin
      a = bus.req_dividend[w*N +: N];
      b = bus.req_divisor[w*N +: N];
      m_a = a; m_b = b; m_id = w; m_busy = 1;
      m_rr = (w + 1) % int'(NREQ);
      if (b == 0) begin
        m_q = '1; m_r = a; m_dbz = 1; m_resp = 1;
      end else begin
        m_start = cyc + 1; m_wait = 1;
      end
    end else if (m_wait && cyc > m_start && bus.div_done) begin
      m_q = m_a / m_b; m_r = m_a % m_b; m_dbz = 0;
      m_wait = 0; m_resp = 1;
    end else if (m_resp && bus.resp_ready) begin
      m_resp = 0; m_busy = 0;
    end
  end

  // Directed stimulus helpers.
  int          r_t;
  logic [31:0] r_id, r_q, r_r, r_dbz;

  task automatic send(input int i, input logic [N-1:0] a, input logic [N-1:0] b, output int t_acc);
    bus.req_dividend[i*N +: N] = a;
    bus.req_divisor[i*N +: N]  = b;
    bus.req_valid[i]           = 1'b1;
    t_acc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.req_ready[i]) begin
        t_acc = cyc;
        break;
      end
    end
    if (t_acc < 0) fail_timeout("accept");
    @(posedge clk); #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_resp();
    r_t = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        r_t = cyc;
        r_id = 32'(bus.resp_id); r_q = 32'(bus.resp_quotient);
        r_r = 32'(bus.resp_remainder); r_dbz = 32'(bus.resp_dbz);
        break;
      end
    end
    if (r_t < 0) fail_timeout("response");
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t_acc, t_st, cnt;
    errors = 0; checks = 0;
    reset = 1'b1;
    bus.req_valid = '1;
    bus.req_dividend = '0;
    bus.req_divisor = '0;
    bus.resp_ready = 1'b1;

    // Reset: req_ready held low even with every requester valid.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_div_start", 32'(bus.div_start), 32'd0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Fairness: all valid, 40+i / 4.
    for (int i = 0; i < int'(NREQ); i++) begin
      bus.req_dividend[i*N +: N] = N'(40 + i);
      bus.req_divisor[i*N +: N]  = N'(4);
    end
    bus.req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      wait_resp();
      chk("fair_id", r_id, 32'(n % 4));
      chk("fair_q", r_q, 32'd10);
      chk("fair_r", r_r, 32'(n % 4));
    end
    bus.req_valid = '0;

    // Single divide: requester 2, 100/7, divider latency 17.
    div_lat = 17;
    send(2, 16'd100, 16'd7, t_acc);
    wait_resp();
    chk("single_id", r_id, 32'd2);
    chk("single_q", r_q, 32'd14);
    chk("single_r", r_r, 32'd2);
    chk("single_dbz", r_dbz, 32'd0);
    chk("single_latency", 32'(r_t - t_acc), 32'd19);
    div_lat = 3;

    // Divide-by-zero: requester 0, 55/0.
    send(0, 16'd55, 16'd0, t_acc);
    wait_resp();
    chk("dbz_id", r_id, 32'd0);
    chk("dbz_q", r_q, 32'hFFFF);
    chk("dbz_r", r_r, 32'd55);
    chk("dbz_flag", r_dbz, 32'd1);
    chk("dbz_latency", 32'(r_t - t_acc), 32'd1);

    // Backpressure: 3/10 from requester 1 held; requester 3 waits meanwhile.
    bus.resp_ready = 1'b0;
    bus.req_dividend[3*N +: N] = 16'd77;
    bus.req_divisor[3*N +: N]  = 16'd5;
    bus.req_valid[3] = 1'b1;
    send(1, 16'd3, 16'd10, t_acc);
    cnt = 0;
    while (!bus.resp_valid && cnt < 100) begin
      @(negedge clk); cnt++;
    end
    if (!bus.resp_valid) fail_timeout("bp_resp");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_id", 32'(bus.resp_id), 32'd1);
      chk("bp_q", 32'(bus.resp_quotient), 32'd0);
      chk("bp_r", 32'(bus.resp_remainder), 32'd3);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_ready", 32'(bus.req_ready), 32'b1000);
    @(posedge clk); #1;
    bus.req_valid[3] = 1'b0;
    wait_resp();
    chk("waiter_id", r_id, 32'd3);
    chk("waiter_q", r_q, 32'd15);
    chk("waiter_r", r_r, 32'd2);

    // Reset mid-WAIT: abort, no response, then 9/3.
    div_lat = 30;
    send(2, 16'd200, 16'd9, t_acc);
    t_st = -1;
    for (int k = 0; k < 20 && t_st < 0; k++) begin
      if (bus.div_start) t_st = cyc;
      else @(negedge clk);
    end
    if (t_st < 0) fail_timeout("rst_start");
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("midrst_div_dividend", 32'(bus.div_dividend), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    div_lat = 3;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.resp_valid) cnt++;
    end
    chk("midrst_no_resp", 32'(cnt), 32'd0);
    @(posedge clk); #1;
    send(1, 16'd9, 16'd3, t_acc);
    wait_resp();
    chk("post_rst_id", r_id, 32'd1);
    chk("post_rst_q", r_q, 32'd3);
    chk("post_rst_r", r_r, 32'd0);

    // Spurious done in IDLE and in RESP.
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    chk("spur_idle_busy", 32'(busy), 32'd0);
    chk("spur_idle_resp", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    send(0, 16'd20, 16'd6, t_acc);
    cnt = 0;
    while (!bus.resp_valid && cnt < 100) begin
      @(negedge clk); cnt++;
    end
    if (!bus.resp_valid) fail_timeout("spur_resp");
    @(posedge clk); #1;
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    chk("spur_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("spur_resp_q", 32'(bus.resp_quotient), 32'd3);
    chk("spur_resp_r", 32'(bus.resp_remainder), 32'd2);
    chk("spur_resp_dbz", 32'(bus.resp_dbz), 32'd0);
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("final_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
